// File: rtl/branch_predictor_pkg.sv
// Shared types and counter constants for the branch target predictor.
`include "nand_cpu.svh"

package branch_predictor_pkg;
  localparam int PC_SIZE = `PC_SIZE;

  // Tag is stored zero-extended to PC width; only pc[PC_W-1:IDX_W] is ever non-zero.
  typedef struct packed {
    logic               valid;
    logic [PC_SIZE-1:0] tag;
    logic [PC_SIZE-1:0] target;
  } bp_entry_t;

  // Reset value: weakly not-taken.
  function automatic int ctr_init(input int bits);
    return (1 << (bits - 1)) - 1;
  endfunction

  // Allocation value: weakly taken.
  function automatic int ctr_weak_taken(input int bits);
    return 1 << (bits - 1);
  endfunction
endpackage

// File: rtl/branch_predictor_if.sv
// Resolved-branch feedback bundle from execute back to the predictor.
`include "nand_cpu.svh"

interface branch_feedback_ifc #(parameter int PC_W = `PC_SIZE);
  logic            fb_branch;
  logic [PC_W-1:0] fb_pc;
  logic            fb_taken;
  logic [PC_W-1:0] fb_target;
  logic            fb_predict_taken;
  logic [PC_W-1:0] fb_predict_target;

  modport master (output fb_branch, fb_pc, fb_taken, fb_target,
                         fb_predict_taken, fb_predict_target);
  modport in     (input  fb_branch, fb_pc, fb_taken, fb_target,
                         fb_predict_taken, fb_predict_target);
endinterface

// File: rtl/branch_predictor_sat_counter.sv
// Saturating up/down counter with parallel load; exposes only the direction bit.
module sat_counter #(
  parameter int            W    = 2,
  parameter logic [W-1:0]  INIT = '0
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         inc,
  input  logic         dec,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         msb
);
  localparam logic [W-1:0] MAX = {W{1'b1}};

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)                     count <= INIT;
    else if (load)                  count <= load_val;
    else if (inc && count != MAX)   count <= count + W'(1);
    else if (dec && count != '0)    count <= count - W'(1);
  end

  assign msb = count[W-1];
endmodule

// File: rtl/nand_cpu.svh
// CPU-wide sizing macros shared by the fetch-side blocks.
`ifndef NAND_CPU_SVH
`define NAND_CPU_SVH
`define PC_SIZE 16
`endif

// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with per-entry saturating direction counters.
`include "nand_cpu.svh"

module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int ENTRIES  = 16,
  parameter int CTR_BITS = 2,
  parameter int PC_W     = `PC_SIZE
) (
  input  logic            clk,
  input  logic            n_rst,
  input  logic [PC_W-1:0] lookup_pc,
  output logic            predict_taken,
  output logic [PC_W-1:0] predict_target,
  branch_feedback_ifc.in  fb,
  input  logic            flush,
  output logic            mispredict,
  output logic [PC_W-1:0] redirect_pc,
  output logic [15:0]     mispredict_count
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'(ctr_init(CTR_BITS));
  localparam logic [CTR_BITS-1:0] CTR_WT   = CTR_BITS'(ctr_weak_taken(CTR_BITS));

  bp_entry_t          tbl [ENTRIES];
  logic [ENTRIES-1:0] ctr_msb;

  logic [IDX_W-1:0]   lk_idx, fb_idx;
  logic [PC_SIZE-1:0] lk_tag, fb_tag;
  logic               lk_hit, fb_hit, upd;

  assign lk_idx = lookup_pc[IDX_W-1:0];
  assign fb_idx = fb.fb_pc[IDX_W-1:0];
  assign lk_tag = PC_SIZE'(lookup_pc >> IDX_W);
  assign fb_tag = PC_SIZE'(fb.fb_pc >> IDX_W);

  assign lk_hit = tbl[lk_idx].valid && (tbl[lk_idx].tag == lk_tag);
  assign fb_hit = tbl[fb_idx].valid && (tbl[fb_idx].tag == fb_tag);

  // Reads see registered state only, so a same-index update lands next cycle.
  assign predict_taken  = lk_hit && ctr_msb[lk_idx];
  assign predict_target = predict_taken ? PC_W'(tbl[lk_idx].target)
                                        : lookup_pc + PC_W'(1);

  assign mispredict  = fb.fb_branch &&
                       ((fb.fb_taken != fb.fb_predict_taken) ||
                        (fb.fb_taken && (fb.fb_target != fb.fb_predict_target)));
  assign redirect_pc = fb.fb_taken ? fb.fb_target : fb.fb_pc + PC_W'(1);

  assign upd = fb.fb_branch && !flush;

  // Taken feedback writes target on a hit and (re)allocates tag/valid on a miss.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i < ENTRIES; i++) tbl[i] <= '0;
    end else if (flush) begin
      for (int i = 0; i < ENTRIES; i++) tbl[i].valid <= 1'b0;
    end else if (upd && fb.fb_taken) begin
      tbl[fb_idx].valid  <= 1'b1;
      tbl[fb_idx].tag    <= fb_tag;
      tbl[fb_idx].target <= PC_SIZE'(fb.fb_target);
    end
  end

  for (genvar i = 0; i < ENTRIES; i++) begin : g_ctr
    logic sel;
    assign sel = upd && (fb_idx == IDX_W'(i));

    sat_counter #(.W(CTR_BITS), .INIT(CTR_INIT)) u_ctr (
      .clk      (clk),
      .n_rst    (n_rst),
      .inc      (sel && fb_hit && fb.fb_taken),
      .dec      (sel && fb_hit && !fb.fb_taken),
      .load     (sel && !fb_hit && fb.fb_taken),
      .load_val (CTR_WT),
      .msb      (ctr_msb[i])
    );
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)                                         mispredict_count <= '0;
    else if (mispredict && mispredict_count != 16'hFFFF) mispredict_count <= mispredict_count + 16'd1;
  end
endmodule

// File: tb/tb_branch_predictor.sv
// Directed table-driven bench for branch_predictor plus flush/saturation/reset sequences.
module tb_branch_predictor;
  import branch_predictor_pkg::*;

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic [15:0] lookup_pc = '0;
  logic        predict_taken;
  logic [15:0] predict_target;
  logic        flush = 1'b0;
  logic        mispredict;
  logic [15:0] redirect_pc;
  logic [15:0] mispredict_count;

  branch_feedback_ifc #(.PC_W(16)) fb_if ();

  branch_predictor #(.ENTRIES(16), .CTR_BITS(2), .PC_W(16)) dut (
    .clk              (clk),
    .n_rst            (n_rst),
    .lookup_pc        (lookup_pc),
    .predict_taken    (predict_taken),
    .predict_target   (predict_target),
    .fb               (fb_if),
    .flush            (flush),
    .mispredict       (mispredict),
    .redirect_pc      (redirect_pc),
    .mispredict_count (mispredict_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        fbb;
    logic [15:0] pc;
    logic        tk;
    logic [15:0] tgt;
    logic        ptk;
    logic [15:0] ptgt;
    logic [15:0] lk;
    logic        e_pt;
    logic [15:0] e_tgt;
    logic        e_mis;
    logic [15:0] e_redir;
  } vec_t;

  vec_t        vecs[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [15:0] exp_cnt = '0;

  function automatic vec_t mk(input logic fbb, input logic [15:0] pc, input logic tk,
                              input logic [15:0] tgt, input logic ptk, input logic [15:0] ptgt,
                              input logic [15:0] lk, input logic e_pt, input logic [15:0] e_tgt,
                              input logic e_mis, input logic [15:0] e_redir);
    vec_t v;
    v.fbb = fbb; v.pc = pc; v.tk = tk; v.tgt = tgt; v.ptk = ptk; v.ptgt = ptgt;
    v.lk = lk; v.e_pt = e_pt; v.e_tgt = e_tgt; v.e_mis = e_mis; v.e_redir = e_redir;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic set_fb(input logic fbb, input logic [15:0] pc, input logic tk,
                        input logic [15:0] tgt, input logic ptk, input logic [15:0] ptgt);
    fb_if.fb_branch = fbb; fb_if.fb_pc = pc; fb_if.fb_taken = tk;
    fb_if.fb_target = tgt; fb_if.fb_predict_taken = ptk; fb_if.fb_predict_target = ptgt;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_lookup(input string nm, input logic [15:0] pc,
                            input logic e_pt, input logic [15:0] e_tgt);
    lookup_pc = pc;
    #1;
    chk({nm, " pt"}, {15'd0, predict_taken}, {15'd0, e_pt});
    chk({nm, " tgt"}, predict_target, e_tgt);
  endtask

  initial begin
    set_fb(1'b0, '0, 1'b0, '0, 1'b0, '0);

    // Vectors start right after reset release; comments give counter state at idx 0.
    vecs.push_back(mk(0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 16'h0040, 0, 16'h0041, 0, 16'h0000));
    vecs.push_back(mk(1, 16'h0040, 1, 16'h0100, 0, 16'h0041, 16'h0040, 0, 16'h0041, 1, 16'h0100)); // alloc ->2
    vecs.push_back(mk(0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 16'h0040, 1, 16'h0100, 0, 16'h0000));
    vecs.push_back(mk(1, 16'h0040, 0, 16'h0000, 1, 16'h0100, 16'h0040, 1, 16'h0100, 1, 16'h0041)); // ->1
    vecs.push_back(mk(1, 16'h0040, 0, 16'h0000, 0, 16'h0041, 16'h0040, 0, 16'h0041, 0, 16'h0000)); // ->0
    vecs.push_back(mk(1, 16'h0040, 0, 16'h0000, 0, 16'h0041, 16'h0040, 0, 16'h0041, 0, 16'h0000)); // stays 0
    vecs.push_back(mk(1, 16'h0040, 1, 16'h0100, 0, 16'h0041, 16'h0040, 0, 16'h0041, 1, 16'h0100)); // ->1
    vecs.push_back(mk(1, 16'h0040, 1, 16'h0100, 0, 16'h0041, 16'h0040, 0, 16'h0041, 1, 16'h0100)); // ->2
    vecs.push_back(mk(0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 16'h0040, 1, 16'h0100, 0, 16'h0000));
    vecs.push_back(mk(1, 16'h0040, 1, 16'h0100, 1, 16'h0100, 16'h0040, 1, 16'h0100, 0, 16'h0000)); // ->3
    vecs.push_back(mk(1, 16'h0040, 1, 16'h0100, 1, 16'h0100, 16'h0040, 1, 16'h0100, 0, 16'h0000)); // stays 3
    vecs.push_back(mk(0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 16'h0040, 1, 16'h0100, 0, 16'h0000));
    vecs.push_back(mk(1, 16'h0040, 1, 16'h0200, 1, 16'h0100, 16'h0040, 1, 16'h0100, 1, 16'h0200)); // new target
    vecs.push_back(mk(0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 16'h0040, 1, 16'h0200, 0, 16'h0000));
    vecs.push_back(mk(1, 16'h0050, 1, 16'h0300, 0, 16'h0051, 16'h0050, 0, 16'h0051, 1, 16'h0300)); // alias evicts
    vecs.push_back(mk(0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 16'h0040, 0, 16'h0041, 0, 16'h0000));
    vecs.push_back(mk(0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 16'h0050, 1, 16'h0300, 0, 16'h0000));
    vecs.push_back(mk(1, 16'h0123, 0, 16'h0999, 0, 16'h0124, 16'h0123, 0, 16'h0124, 0, 16'h0000)); // nt miss
    vecs.push_back(mk(0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 16'h0123, 0, 16'h0124, 0, 16'h0000));
    vecs.push_back(mk(0, 16'h0000, 1, 16'h0500, 0, 16'h0000, 16'hFFFF, 0, 16'h0000, 0, 16'h0000));
    vecs.push_back(mk(1, 16'h0061, 1, 16'h0600, 0, 16'h0062, 16'h0061, 0, 16'h0062, 1, 16'h0600));
    vecs.push_back(mk(0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 16'h0061, 1, 16'h0600, 0, 16'h0000));

    // Reset state, including combinational mispredict while held in reset
    #2;
    chk_lookup("rst lookup", 16'h0040, 1'b0, 16'h0041);
    chk("rst count", mispredict_count, 16'h0000);
    set_fb(1'b1, 16'h0040, 1'b1, 16'h0100, 1'b0, 16'h0041);
    #1;
    chk("rst mispredict", {15'd0, mispredict}, 16'h0001);
    set_fb(1'b0, '0, 1'b0, '0, 1'b0, '0);
    tick();
    n_rst = 1'b1;

    foreach (vecs[i]) begin
      set_fb(vecs[i].fbb, vecs[i].pc, vecs[i].tk, vecs[i].tgt, vecs[i].ptk, vecs[i].ptgt);
      lookup_pc = vecs[i].lk;
      #2;
      chk($sformatf("v%0d pt", i), {15'd0, predict_taken}, {15'd0, vecs[i].e_pt});
      chk($sformatf("v%0d tgt", i), predict_target, vecs[i].e_tgt);
      chk($sformatf("v%0d mis", i), {15'd0, mispredict}, {15'd0, vecs[i].e_mis});
      if (vecs[i].e_mis) chk($sformatf("v%0d redir", i), redirect_pc, vecs[i].e_redir);
      if (vecs[i].e_mis && exp_cnt != 16'hFFFF) exp_cnt++;
      tick();
    end
    set_fb(1'b0, '0, 1'b0, '0, 1'b0, '0);
    chk("count after vecs", mispredict_count, exp_cnt);

    // Flush with a same-cycle taken feedback: flush wins, count untouched
    flush = 1'b1;
    set_fb(1'b1, 16'h0072, 1'b1, 16'h0700, 1'b1, 16'h0700);
    chk_lookup("pre-flush", 16'h0050, 1'b1, 16'h0300);
    chk("flush-cycle mis", {15'd0, mispredict}, 16'h0000);
    tick();
    flush = 1'b0;
    set_fb(1'b0, '0, 1'b0, '0, 1'b0, '0);
    chk_lookup("post-flush 0050", 16'h0050, 1'b0, 16'h0051);
    chk_lookup("post-flush 0061", 16'h0061, 1'b0, 16'h0062);
    chk_lookup("post-flush 0072", 16'h0072, 1'b0, 16'h0073);
    chk("count after flush", mispredict_count, exp_cnt);
    tick();

    // Statistic saturation
    set_fb(1'b1, 16'h0040, 1'b1, 16'h0100, 1'b0, 16'h0041);
    for (int k = 0; k < 65540; k++) begin
      tick();
      if (exp_cnt != 16'hFFFF) exp_cnt++;
    end
    chk("count model", mispredict_count, exp_cnt);
    chk("count sat", mispredict_count, 16'hFFFF);

    // Async reset mid-cycle; an update presented during reset is discarded
    set_fb(1'b1, 16'h0080, 1'b1, 16'h0500, 1'b1, 16'h0500);
    #1;
    n_rst = 1'b0;
    #1;
    chk("async rst count", mispredict_count, 16'h0000);
    chk_lookup("async rst lookup", 16'h0040, 1'b0, 16'h0041);
    tick();
    set_fb(1'b0, '0, 1'b0, '0, 1'b0, '0);
    n_rst = 1'b1;
    chk_lookup("discarded update", 16'h0080, 1'b0, 16'h0081);
    tick();
    chk_lookup("still missing", 16'h0080, 1'b0, 16'h0081);
    chk("count after rst", mispredict_count, 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
